uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : uart_rx_ctrl
// Brief    : UART receive frame controller; sequences start/data/parity/stop
//            around an external oversampling majority-vote sampler.
// Revision : 1.0  initial release
//==============================================================================
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  S_BIT,
   input  logic                  SAMPLE_DONE,
   output logic                  SAMPLE_EN,
   output logic [5:0]            EDGE_COUNT,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR,
   output logic                  BUSY
);

   localparam int               c_BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [c_BCW-1:0] c_LAST_BIT = c_BCW'(DATA_WIDTH - 1);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_START  = 3'd1;
   localparam logic [2:0] c_DATA   = 3'd2;
   localparam logic [2:0] c_PARITY = 3'd3;
   localparam logic [2:0] c_STOP   = 3'd4;

   logic [2:0]            r_state;
   logic [2:0]            w_next_state;
   logic [5:0]            r_edge_cnt;
   logic [5:0]            r_ps;
   logic                  r_par_en;
   logic                  r_par_typ;
   logic [c_BCW-1:0]      r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic [DATA_WIDTH-1:0] r_p_data;
   logic                  r_data_valid;
   logic                  r_par_err;
   logic                  r_stp_err;
   logic                  w_start_det;
   logic                  w_bit_end;
   logic                  w_glitch;
   logic                  w_stop_bad;
   logic                  w_frame_ok;

   assign w_start_det = (r_state == c_IDLE) && !RX_IN;
   assign w_bit_end   = (r_edge_cnt == (r_ps - 6'd1));
   assign w_glitch    = (r_state == c_START) && SAMPLE_DONE && S_BIT;
   assign w_stop_bad  = (r_state == c_STOP) && SAMPLE_DONE && !S_BIT;
   // A stop-bit sample landing on the boundary cycle must still veto the word.
   assign w_frame_ok  = (r_state == c_STOP) && w_bit_end && !r_par_err
                        && !r_stp_err && !w_stop_bad;

   generate
      if (DATA_WIDTH > 1) begin : g_shift_wide
         assign w_shift_next = {S_BIT, r_shift[DATA_WIDTH-1:1]};
      end else begin : g_shift_bit
         assign w_shift_next = S_BIT;
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (!RX_IN) w_next_state = c_START;
         end
         c_START: begin
            if (w_glitch)       w_next_state = c_IDLE;
            else if (w_bit_end) w_next_state = c_DATA;
         end
         c_DATA: begin
            if (w_bit_end && (r_bit_cnt == c_LAST_BIT))
               w_next_state = r_par_en ? c_PARITY : c_STOP;
         end
         c_PARITY: begin
            if (w_bit_end) w_next_state = c_STOP;
         end
         c_STOP: begin
            if (w_bit_end) w_next_state = c_IDLE;
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      SAMPLE_EN = 1'b0;
      BUSY      = 1'b0;
      if (r_state != c_IDLE) begin
         SAMPLE_EN = 1'b1;
         BUSY      = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_edge_cnt <= '0;
      end else if ((r_state == c_IDLE) || (w_next_state == c_IDLE) || w_bit_end) begin
         r_edge_cnt <= '0;
      end else begin
         r_edge_cnt <= r_edge_cnt + 6'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_ps         <= '0;
         r_par_en     <= 1'b0;
         r_par_typ    <= 1'b0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_p_data     <= '0;
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         // Frame configuration is frozen here so mid-frame input changes are ignored.
         if (w_start_det) begin
            r_ps      <= PRESCALE;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
         end
         if (r_state == c_DATA) begin
            if (SAMPLE_DONE) r_shift   <= w_shift_next;
            if (w_bit_end)   r_bit_cnt <= r_bit_cnt + c_BCW'(1);
         end
         if ((r_state == c_PARITY) && SAMPLE_DONE && (S_BIT != ((^r_shift) ^ r_par_typ)))
            r_par_err <= 1'b1;
         if (w_stop_bad)
            r_stp_err <= 1'b1;
         if (w_frame_ok) begin
            r_p_data     <= r_shift;
            r_data_valid <= 1'b1;
         end
      end
   end

   assign EDGE_COUNT = r_edge_cnt;
   assign P_DATA     = r_p_data;
   assign DATA_VALID = r_data_valid;
   assign PAR_ERR    = r_par_err;
   assign STP_ERR    = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Scoreboard bench for uart_rx_ctrl with a mid-bit sampler model.
// Revision : 1.0  initial release
//==============================================================================
module tb_uart_rx_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RX_IN = 1'b1;
   logic [5:0] PRESCALE = 6'd8;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       S_BIT = 1'b0;
   logic       SAMPLE_DONE = 1'b0;
   logic       SAMPLE_EN;
   logic [5:0] EDGE_COUNT;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_ERR;
   logic       STP_ERR;
   logic       BUSY;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc        = 0;
   int   compared   = 0;
   int   mismatched = 0;
   int   free_cyc   = 0;
   int   cur_ps     = 8;
   bit   idle_poke  = 1'b0;

   uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .S_BIT(S_BIT),
      .SAMPLE_DONE(SAMPLE_DONE), .SAMPLE_EN(SAMPLE_EN),
      .EDGE_COUNT(EDGE_COUNT), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
      .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sampler stand-in: votes the line at the middle of each bit period.
   always @(negedge CLK) begin
      if (SAMPLE_EN && (EDGE_COUNT == 6'(cur_ps / 2))) begin
         SAMPLE_DONE = 1'b1;
         S_BIT       = RX_IN;
      end else begin
         SAMPLE_DONE = idle_poke;
         S_BIT       = 1'b0;
      end
   end

   // Monitor: every DATA_VALID pulse must match the oldest expected word and cycle.
   always @(negedge CLK) begin
      if (DATA_VALID) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL dv_unexpected: actual=pulse data 0x%0h at cycle %0d required=no pulse",
                     P_DATA, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("dv_data", 32'(P_DATA), 32'(e.data));
            check("dv_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input int ps, input bit pe, input bit pt,
                             input bit bad_par, input bit stop_bit);
      logic par;
      int   nb;
      int   c_eff;
      exp_t e;
      par = (^d) ^ pt;
      if (bad_par) par = ~par;
      nb       = pe ? 11 : 10;
      PRESCALE = 6'(ps);
      PAR_EN   = pe;
      PAR_TYP  = pt;
      cur_ps   = ps;
      c_eff    = (cyc > free_cyc) ? cyc : free_cyc;
      free_cyc = c_eff + nb * ps + 1;
      if (!bad_par && stop_bit) begin
         e.data = d;
         e.cyc  = free_cyc;
         sb.push_back(e);
      end
      RX_IN = 1'b0;
      repeat (ps) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RX_IN = d[i];
         repeat (ps) @(negedge CLK);
      end
      if (pe) begin
         RX_IN = par;
         repeat (ps) @(negedge CLK);
      end
      RX_IN = stop_bit;
      repeat (ps) @(negedge CLK);
      RX_IN = 1'b1;
   endtask

   task automatic wait_end(input string tag);
      while (cyc < free_cyc - 1) @(negedge CLK);
      check({tag, "_busy_last"}, 32'(BUSY), 32'd1);
      @(negedge CLK);
      check({tag, "_busy_done"}, 32'(BUSY), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sample_en"}, 32'(SAMPLE_EN), 32'd0);
      check({tag, "_edge_count"}, 32'(EDGE_COUNT), 32'd0);
      check({tag, "_p_data"}, 32'(P_DATA), 32'd0);
      check({tag, "_data_valid"}, 32'(DATA_VALID), 32'd0);
      check({tag, "_par_err"}, 32'(PAR_ERR), 32'd0);
      check({tag, "_stp_err"}, 32'(STP_ERR), 32'd0);
      check({tag, "_busy"}, 32'(BUSY), 32'd0);
   endtask

   initial begin
      #500000;
      mismatched++;
      $display("FAIL watchdog: actual=still running required=finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [7:0] lost;
      #2 RST = 1'b0;
      repeat (3) @(negedge CLK);
      check_all_zero("rst");
      RST = 1'b1;
      repeat (3) @(negedge CLK);

      // Sampler pulses while idle must not start anything.
      idle_poke = 1'b1;
      repeat (3) @(negedge CLK);
      idle_poke = 1'b0;
      @(negedge CLK);
      check("poke_busy", 32'(BUSY), 32'd0);
      check("poke_edge", 32'(EDGE_COUNT), 32'd0);

      // Good 0xA5, even parity (bit 0); config inputs change mid-frame.
      fork
         send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1);
         begin
            repeat (5) @(negedge CLK);
            PRESCALE = 6'd32;
            PAR_EN   = 1'b0;
            PAR_TYP  = 1'b1;
            check("a5_busy_mid", 32'(BUSY), 32'd1);
            check("a5_sample_en_mid", 32'(SAMPLE_EN), 32'd1);
         end
      join
      wait_end("a5");
      check("a5_p_data", 32'(P_DATA), 32'hA5);
      check("a5_par_err", 32'(PAR_ERR), 32'd0);
      check("a5_stp_err", 32'(STP_ERR), 32'd0);

      // Start glitch: line low two cycles, sampler votes 1.
      repeat (4) @(negedge CLK);
      PRESCALE = 6'd8;
      cur_ps   = 8;
      RX_IN    = 1'b0;
      repeat (2) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (2) @(negedge CLK);
      check("glitch_busy_start", 32'(BUSY), 32'd1);
      repeat (2) @(negedge CLK);
      check("glitch_busy_idle", 32'(BUSY), 32'd0);
      check("glitch_edge", 32'(EDGE_COUNT), 32'd0);
      check("glitch_par_err", 32'(PAR_ERR), 32'd0);
      check("glitch_stp_err", 32'(STP_ERR), 32'd0);
      repeat (10) @(negedge CLK);

      // Good 0x5A, odd parity (bit 1).
      send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b0, 1'b1);
      wait_end("5a");
      check("5a_p_data", 32'(P_DATA), 32'h5A);
      check("5a_par_err", 32'(PAR_ERR), 32'd0);

      // 0xA5 even parity with wrong parity bit 1.
      repeat (3) @(negedge CLK);
      send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1);
      wait_end("perr");
      check("perr_par_err", 32'(PAR_ERR), 32'd1);
      check("perr_stp_err", 32'(STP_ERR), 32'd0);
      check("perr_p_data", 32'(P_DATA), 32'h5A);

      // 0x3C no parity, stop bit 0.
      repeat (3) @(negedge CLK);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_end("serr");
      check("serr_stp_err", 32'(STP_ERR), 32'd1);
      check("serr_par_err", 32'(PAR_ERR), 32'd0);
      check("serr_p_data", 32'(P_DATA), 32'h5A);

      // Good 0x81 clears the stop error at its start.
      repeat (3) @(negedge CLK);
      fork
         send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
         begin
            repeat (3) @(negedge CLK);
            check("81_stp_err_cleared", 32'(STP_ERR), 32'd0);
         end
      join
      wait_end("81");
      check("81_p_data", 32'(P_DATA), 32'h81);

      // Back-to-back 0x00 then 0xFF at PRESCALE 16, no idle on the line.
      repeat (3) @(negedge CLK);
      send_frame(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_end("b2b");
      check("b2b_p_data", 32'(P_DATA), 32'hFF);

      // Reset asserted during data bit 3 of an abandoned frame.
      repeat (3) @(negedge CLK);
      lost     = 8'h6B;
      cur_ps   = 8;
      PRESCALE = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      repeat (8) @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         RX_IN = lost[i];
         repeat (8) @(negedge CLK);
      end
      RX_IN = lost[3];
      repeat (3) @(negedge CLK);
      check("mid_busy_before_rst", 32'(BUSY), 32'd1);
      RST = 1'b0;
      #1;
      check_all_zero("mid_rst");
      RX_IN = 1'b1;
      @(negedge CLK);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      check_all_zero("post_rst");
      free_cyc = cyc;
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_end("c3");
      check("c3_p_data", 32'(P_DATA), 32'hC3);
      check("c3_stp_err", 32'(STP_ERR), 32'd0);

      repeat (5) @(negedge CLK);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
